// File: rtl/cr_crc_mc_pkg.sv
// Shared types, default geometry and the reflected CRC step for cr_crc_mc.
// crc_step works at the widest legal sizes; callers zero-extend and truncate.
package cr_crc_mc_pkg;

   localparam int DEF_CRC_WIDTH  = 32;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_N_CHAN     = 4;
   localparam int CHAN_W         = (DEF_N_CHAN > 1) ? $clog2(DEF_N_CHAN) : 1;
   localparam int VB_W           = DEF_DATA_WIDTH / 8;
   localparam int MAX_CRC_W      = 64;
   localparam int MAX_DATA_W     = 256;

   typedef logic [DEF_CRC_WIDTH-1:0] crc_t;

   // Upper register bits stay zero as long as base and poly are zero-extended.
   function automatic logic [MAX_CRC_W-1:0] crc_step(
      input logic [MAX_CRC_W-1:0]  base,
      input logic [MAX_DATA_W-1:0] data,
      input int unsigned           nbytes,
      input logic [MAX_CRC_W-1:0]  poly
   );
      logic [MAX_CRC_W-1:0] crc;
      logic                 fb;
      crc = base;
      for (int unsigned i = 0; i < MAX_DATA_W / 8; i++) begin
         if (i < nbytes) begin
            for (int unsigned b = 0; b < 8; b++) begin
               fb  = crc[0] ^ data[8*i+b];
               crc = crc >> 1;
               if (fb) crc = crc ^ poly;
            end
         end
      end
      return crc;
   endfunction

endpackage

// File: rtl/cr_crc_mc_vbdec.sv
// Byte-valid mask decoder: counts thermometer bytes from byte 0 and flags
// any mask with a hole; an illegal mask decodes to zero bytes.
module cr_crc_mc_vbdec #(
   parameter int W    = 8,
   parameter int NB_W = $clog2(W + 1)
) (
   input  logic [W-1:0]    vbytes,
   output logic [NB_W-1:0] nbytes,
   output logic            illegal
);

   int cnt;

   // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch can form.
   always_comb begin
      cnt     = 0;
      illegal = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (vbytes[i]) cnt = cnt + 1;
      end
      for (int i = 1; i < W; i++) begin
         if (vbytes[i] && !vbytes[i-1]) illegal = 1'b1;
      end
      nbytes = illegal ? '0 : NB_W'(cnt);
   end

endmodule

// File: rtl/cr_crc_mc.sv
// Multi-channel CRC accumulator with per-channel running contexts and a
// registered result port. Optional residue check: define CR_CRC_MC_CHECK_EN.
module cr_crc_mc
   import cr_crc_mc_pkg::*;
#(
   parameter int                   CRC_WIDTH  = DEF_CRC_WIDTH,
   parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                   N_CHAN     = DEF_N_CHAN,
   parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = CRC_WIDTH'(32'h82F63B78),
   parameter logic [CRC_WIDTH-1:0] INIT_VALUE = '1,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '1,
   parameter logic [CRC_WIDTH-1:0] RESIDUE    = CRC_WIDTH'(32'hB798B438),
   localparam int                  CW         = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
   localparam int                  NB         = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CW-1:0]         in_chan,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [NB-1:0]         in_vbytes,
   input  logic                  in_sof,
   input  logic                  in_eof,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         out_chan,
   output logic [CRC_WIDTH-1:0]  out_crc,
   output logic                  out_match,
   output logic                  err_vbytes,
   output logic [N_CHAN-1:0]     ctx_busy
);

   localparam int NB_W = $clog2(NB + 1);

   logic [CRC_WIDTH-1:0] ctx [N_CHAN];
   logic [CRC_WIDTH-1:0] base;
   logic [CRC_WIDTH-1:0] new_crc;
   logic [NB_W-1:0]      nbytes;
   logic                 vb_illegal;
   logic                 accept;

   // Single output register: a new beat may enter whenever the slot drains this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   cr_crc_mc_vbdec #(
      .W    (NB),
      .NB_W (NB_W)
   ) u_vbdec (
      .vbytes  (in_vbytes),
      .nbytes  (nbytes),
      .illegal (vb_illegal)
   );

   always_comb begin
      base = INIT_VALUE;
      if (!in_sof) begin
         for (int c = 0; c < N_CHAN; c++) begin
            if (in_chan == CW'(c)) base = ctx[c];
         end
      end
   end

   assign new_crc = CRC_WIDTH'(crc_step(64'(base), 256'(in_data), 32'(nbytes), 64'(POLYNOMIAL)));

   // NOTE: contexts are small flop arrays, so they take the reset like any register; a RAM would not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CHAN; c++) ctx[c] <= INIT_VALUE;
         ctx_busy <= '0;
      end else if (accept) begin
         for (int c = 0; c < N_CHAN; c++) begin
            if (in_chan == CW'(c)) begin
               ctx[c] <= in_eof ? INIT_VALUE : new_crc;
               if (in_eof)      ctx_busy[c] <= 1'b0;
               else if (in_sof) ctx_busy[c] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_chan   <= '0;
         out_crc    <= '0;
         err_vbytes <= 1'b0;
      end else begin
         err_vbytes <= accept && vb_illegal;
         if (accept && in_eof) begin
            out_valid <= 1'b1;
            out_chan  <= in_chan;
            out_crc   <= new_crc ^ XOR_OUT;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef CR_CRC_MC_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 out_match <= 1'b0;
      else if (accept && in_eof)  out_match <= (new_crc == RESIDUE);
   end
`else
   logic unused_residue;
   assign unused_residue = ^RESIDUE;
   assign out_match      = 1'b0;
`endif

endmodule

// File: tb/tb_cr_crc_mc.sv
// Self-checking bench for cr_crc_mc: table-driven beats feed a result
// scoreboard, followed by hand-written stall and mid-frame reset sequences.
module tb_cr_crc_mc;
   import cr_crc_mc_pkg::*;

`ifdef CR_CRC_MC_CHECK_EN
   localparam bit MATCH_EN = 1'b1;
`else
   localparam bit MATCH_EN = 1'b0;
`endif

   localparam logic [31:0] REF_CRC = 32'hE3069283;
   localparam logic [63:0] S1_8    = 64'h3837363534333231;

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      logic [63:0]       data;
      logic [VB_W-1:0]   vb;
      logic              sof;
      logic              eof;
      logic              err;
      crc_t              crc;
      logic              match;
   } vec_t;

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      crc_t              crc;
      logic              match;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid, in_ready, in_sof, in_eof;
   logic [CHAN_W-1:0] in_chan;
   logic [63:0]       in_data;
   logic [VB_W-1:0]   in_vbytes;
   logic              out_valid, out_ready, out_match, err_vbytes;
   logic [CHAN_W-1:0] out_chan;
   crc_t              out_crc;
   logic [3:0]        ctx_busy;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[$];
   logic [3:0] busy_m;

   always #5 clk = ~clk;

   cr_crc_mc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_chan    (in_chan),
      .in_data    (in_data),
      .in_vbytes  (in_vbytes),
      .in_sof     (in_sof),
      .in_eof     (in_eof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_chan   (out_chan),
      .out_crc    (out_crc),
      .out_match  (out_match),
      .err_vbytes (err_vbytes),
      .ctx_busy   (ctx_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int ch, input logic [63:0] d, input logic [7:0] vb,
                               input bit sof, input bit eof, input bit err,
                               input logic [31:0] crc, input bit m);
      vec_t v;
      v.chan  = CHAN_W'(ch);
      v.data  = d;
      v.vb    = vb;
      v.sof   = sof;
      v.eof   = eof;
      v.err   = err;
      v.crc   = crc;
      v.match = m;
      return v;
   endfunction

   // Drive one beat, wait (bounded) for acceptance, then check the side effects.
   task automatic send(input vec_t v);
      int   n;
      exp_t e;
      in_valid  = 1'b1;
      in_chan   = v.chan;
      in_data   = v.data;
      in_vbytes = v.vb;
      in_sof    = v.sof;
      in_eof    = v.eof;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 64'(in_ready), 64'(1));
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (v.eof) begin
         e.chan  = v.chan;
         e.crc   = v.crc;
         e.match = v.match;
         sb.push_back(e);
         busy_m[v.chan] = 1'b0;
      end else if (v.sof) begin
         busy_m[v.chan] = 1'b1;
      end
      check("err_vbytes", 64'(err_vbytes), 64'(v.err));
      check("ctx_busy", 64'(ctx_busy), 64'(busy_m));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got chan %0d crc %h expected none", out_chan, out_crc);
         end else begin
            mon_e = sb.pop_front();
            check("out_chan", 64'(out_chan), 64'(mon_e.chan));
            check("out_crc", 64'(out_crc), 64'(mon_e.crc));
            check("out_match", 64'(out_match), 64'(mon_e.match));
         end
      end
   end

   initial begin
      int n;
      in_valid  = 1'b0;
      in_chan   = '0;
      in_data   = '0;
      in_vbytes = '0;
      in_sof    = 1'b0;
      in_eof    = 1'b0;
      out_ready = 1'b1;
      busy_m    = '0;

      // chan, data, vbytes, sof, eof, err, expected crc, expected match
      vecs.push_back(mk(0, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 64'h39, 8'h01, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(1, 64'h34333231, 8'h0F, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(2, 64'h333231, 8'h07, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(1, 64'h3938373635, 8'h1F, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(2, 64'h393837363534, 8'h3F, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(3, 64'h34333231, 8'h0F, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(3, S1_8, 8'h05, 0, 0, 1, 32'h0, 0));
      vecs.push_back(mk(3, 64'h3938373635, 8'h1F, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(2, 64'h0, 8'h00, 1, 1, 0, 32'h00000000, 0));
      vecs.push_back(mk(1, S1_8, 8'hFF, 0, 0, 0, 32'h0, 0));
      vecs.push_back(mk(1, 64'h39, 8'h01, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(0, 64'hDEADBEEFCAFEF00D, 8'hFF, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(0, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 64'h39, 8'h01, 0, 1, 0, REF_CRC, 0));
      vecs.push_back(mk(3, 64'hFF, 8'h02, 1, 1, 1, 32'h00000000, 0));
      vecs.push_back(mk(2, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      vecs.push_back(mk(2, 64'h000000E306928339, 8'h1F, 0, 1, 0, 32'h48674BC7, MATCH_EN));

      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_chan", 64'(out_chan), 64'(0));
      check("rst_out_crc", 64'(out_crc), 64'(0));
      check("rst_out_match", 64'(out_match), 64'(0));
      check("rst_err_vbytes", 64'(err_vbytes), 64'(0));
      check("rst_ctx_busy", 64'(ctx_busy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) send(vecs[i]);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Output backpressure: result held, input blocked, then drain and accept together.
      out_ready = 1'b0;
      send(mk(0, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      send(mk(0, 64'h39, 8'h01, 0, 1, 0, REF_CRC, 0));
      in_valid  = 1'b1;
      in_chan   = CHAN_W'(1);
      in_data   = '0;
      in_vbytes = '0;
      in_sof    = 1'b1;
      in_eof    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'(0));
         check("stall_out_valid", 64'(out_valid), 64'(1));
         check("stall_out_chan", 64'(out_chan), 64'(0));
         check("stall_out_crc", 64'(out_crc), 64'(REF_CRC));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      sb.push_back('{chan: CHAN_W'(1), crc: 32'h00000000, match: 1'b0});
      in_valid = 1'b0;
      @(negedge clk);
      check("release_out_valid", 64'(out_valid), 64'(1));
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-frame discards the open frame; the next frame starts clean.
      send(mk(0, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ctx_busy", 64'(ctx_busy), 64'(0));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      busy_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(mk(0, S1_8, 8'hFF, 1, 0, 0, 32'h0, 0));
      send(mk(0, 64'h39, 8'h01, 0, 1, 0, REF_CRC, 0));
      in_valid = 1'b0;

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      #20;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cr_crc_mc.md
Name: cr_crc_mc

Overview:
Multi-channel, parametrised CRC accumulator for the compression/crypto datapath, and the successor of the single-stream CRC engine. It accepts byte-masked data beats over a valid/ready handshake, each tagged with a channel ID. It keeps one running CRC context per channel and emits a per-frame result over a registered valid/ready output. Frames on different channels may interleave beat by beat.

Parameters:
POLYNOMIAL, 32'h82F63B78, reflected generator polynomial (CRC-32C by default); LSB-first processing.
CRC_WIDTH, 32, CRC register width; legal range 8..64.
DATA_WIDTH, 64, data beat width; multiple of 8, range 8..256.
N_CHAN, 4, number of independent channel contexts; 1..32.
INIT_VALUE, all-ones, context value loaded at start of frame.
XOR_OUT, all-ones, value XORed into the result on output.
RESIDUE, 32'hB798B438, raw-register residue for a good codeword. Used only with the optional feature.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_chan  in  $clog2(N_CHAN) (min 1)  channel of beat
in_data  in  DATA_WIDTH  data; byte 0 = bits [7:0], processed first
in_vbytes  in  DATA_WIDTH/8  thermometer byte-valid mask from byte 0
in_sof  in  1  first beat of frame
in_eof  in  1  last beat of frame
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_chan  out  $clog2(N_CHAN)  channel of result
out_crc  out  CRC_WIDTH  final CRC (raw register ^ XOR_OUT)
out_match  out  1  raw register == RESIDUE (optional feature)
err_vbytes  out  1  one-cycle pulse: accepted beat had a non-thermometer mask
ctx_busy  out  N_CHAN  per-channel frame-open flags

Behaviour:
- Reset: all contexts = INIT_VALUE; ctx_busy=0; out_valid=0; out_chan=0; out_crc=0; out_match=0; err_vbytes=0. Reset asserted mid-frame discards all state.
- Handshake: in_ready = !out_valid || out_ready, combinational from out_ready. This gives single-entry output skid-free backpressure.
- Accepted beat, base selection: base = INIT_VALUE if in_sof, else ctx[in_chan].
- Accepted beat, update: new = CRC of base over the valid bytes, one cycle. ctx[in_chan] <= new.
- Back-to-back beats on the same channel are legal with no bubble.
- Mask legality: all-zero mask with sof/eof is legal and processes no data. Non-thermometer mask processes 0 bytes and pulses err_vbytes the next cycle. sof and eof are still honoured for such a beat.
- ctx_busy: set on an accepted sof without eof; cleared on an accepted eof.
- Beat without sof on an idle channel: processed from the stored context (INIT_VALUE after reset or after the last eof).
- sof on a busy channel: restarts the frame silently.
- End of frame: on an accepted eof beat, on the next cycle out_valid=1, out_chan=in_chan, out_crc=new ^ XOR_OUT, out_match=(new==RESIDUE), and ctx[in_chan] <= INIT_VALUE.
- Output hold: out_* stay stable while out_valid && !out_ready.
- sof && eof on one beat: single-beat frame.
- Latency: eof accept to out_valid = 1 cycle. Throughput: one beat per cycle when out_ready=1.

Optional Feature:
CR_CRC_MC_CHECK_EN
- Defined: out_match computed as above; the RESIDUE comparator is present.
- Undefined: out_match tied 0; no comparator logic.

Decomposition:
- Package cr_crc_mc_pkg holds:
  - localparams CHAN_W and VB_W;
  - typedef crc_t (logic [CRC_WIDTH-1:0]);
  - the function crc_step(base, data, nbytes), bit-serial over LSB-first reflected bits, unrolled.
- One sub-module, cr_crc_mc_vbdec: combinational thermometer mask to byte count plus illegal flag.
- Context storage is flops, not RAM, because N_CHAN is small.

Test Plan:
1. Chan 0: beat {"12345678", vbytes 8'hFF, sof}, then {"9", 8'h01, eof} -> one cycle later out_valid=1, out_chan=0, out_crc=32'hE3069283; out_match=1 when CR_CRC_MC_CHECK_EN is defined and the message is followed by its CRC bytes.
2. Interleave chan 1 and chan 2, each receiving "123456789" alternately beat by beat -> two results, both 32'hE3069283, in eof order.
3. Hold out_ready=0 for 5 cycles with a result pending -> in_ready=0 and out_* stable; on release the result is consumed and the next beat is accepted that same cycle.
4. Beat with vbytes 8'h05 on chan 3 -> err_vbytes pulses, ctx[3] unchanged, and a subsequent valid frame yields the correct CRC.
5. Assert rst_n low mid-frame on chan 0 -> ctx_busy=0 and out_valid=0; the next sof frame produces the reference CRC.
6. sof && eof with vbytes 8'h00 -> out_crc = INIT_VALUE ^ XOR_OUT = 32'h00000000.
